// File: rtl/rand_event_gen_pkg.sv
// Shared game package: event codes, scheduler FSM encodings and widths.
package rand_event_gen_pkg;

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned EVT_W  = 2;
  localparam int unsigned DROP_W = 4;
  localparam int unsigned RAND_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  typedef enum logic [EVT_W-1:0] {
    EVT_HUNGER  = 2'd0,
    EVT_BOREDOM = 2'd1,
    EVT_POOP    = 2'd2,
    EVT_SICK    = 2'd3
  } evt_e;

endpackage

// File: rtl/rand_event_gen.sv
// Random pet-event scheduler: waits a random number of game ticks, then
// raises a typed event on a valid/ready output, counting events lost while
// an earlier one is still unconsumed.
module rand_event_gen
  import rand_event_gen_pkg::*;
#(
  parameter logic [7:0] MIN_INTERVAL  = 8'd16,
  parameter logic [7:0] INTERVAL_MASK = 8'h3F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAND_W-1:0] rand_in,
  input  logic              tick,
  input  logic              enable,
  output logic              evt_valid,
  output logic [EVT_W-1:0]  evt_type,
  input  logic              evt_ready,
  output logic [DROP_W-1:0] evt_dropped
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  evt_e                type_q, type_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                fire_c;
  logic                accept_c;

  // Low three random bits pick the event; hunger is the most common outcome.
  function automatic evt_e map_type(input logic [2:0] r);
    evt_e t;
    case (r)
      3'd0, 3'd1, 3'd2: t = EVT_HUNGER;
      3'd3, 3'd4:       t = EVT_BOREDOM;
      3'd5, 3'd6:       t = EVT_POOP;
      default:          t = EVT_SICK;
    endcase
    return t;
  endfunction

  // Scheduler next state: reload interval, count ticks down, fire at one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_c  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_LOAD;
        ST_LOAD: begin
          cnt_d   = CNT_W'(MIN_INTERVAL) + CNT_W'(rand_in & INTERVAL_MASK);
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (tick) begin
            if (cnt_q > CNT_W'(1)) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else if (cnt_q == CNT_W'(1)) begin
              fire_c  = 1'b1;
              state_d = ST_LOAD;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Event slot: latch on fire when free or being consumed, else count a drop.
  always_comb begin
    valid_d  = valid_q;
    type_d   = type_q;
    drop_d   = drop_q;
    accept_c = valid_q & evt_ready;
    if (fire_c) begin
      if (!valid_q || accept_c) begin
        valid_d = 1'b1;
        type_d  = map_type(rand_in[2:0]);
      end else if (drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end else if (accept_c) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      type_q  <= EVT_HUNGER;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      drop_q  <= drop_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_type    = type_q;
  assign evt_dropped = drop_q;

endmodule

// File: tb/tb_rand_event_gen.sv
// Scoreboard bench for rand_event_gen: expected event types are queued when
// a firing tick is driven and popped when the consumer accepts the event.
module tb_rand_event_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rand_in;
  logic       tick;
  logic       enable;
  logic       evt_ready;
  logic       evt_valid,  evt_valid1;
  logic [1:0] evt_type,   evt_type1;
  logic [3:0] evt_dropped, evt_dropped1;

  always #5 clk = ~clk;

  rand_event_gen u_dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .tick(tick), .enable(enable),
    .evt_valid(evt_valid), .evt_type(evt_type), .evt_ready(evt_ready),
    .evt_dropped(evt_dropped)
  );

  rand_event_gen #(.MIN_INTERVAL(8'd1), .INTERVAL_MASK(8'h3F)) u_dut_min (
    .clk(clk), .rst(rst), .rand_in(rand_in), .tick(tick), .enable(enable),
    .evt_valid(evt_valid1), .evt_type(evt_type1), .evt_ready(evt_ready),
    .evt_dropped(evt_dropped1)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         q[$];
  bit         exp_valid;
  int         exp_drop;
  logic [7:0] base_r;
  int         load_len;
  int         type_tbl[8] = '{0, 0, 0, 1, 1, 2, 2, 3};

  task automatic chk(input string tag, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reload byte used at every LOAD; interval = MIN + (byte & MASK).
  task automatic set_base(input logic [7:0] r);
    base_r   = r;
    rand_in  = r;
    load_len = 16 + int'(r & 8'h3F);
  endtask

  // Entered in COUNT with a full interval; leaves in COUNT after the reload.
  task automatic do_fire(input logic [7:0] fire_r, input bit ready);
    tick = 1'b1;
    for (int i = 1; i < load_len; i++) cyc();
    chk("pre_fire_valid", int'(evt_valid), int'(exp_valid));
    rand_in   = fire_r;
    evt_ready = ready;
    if (ready && exp_valid) begin
      chk("acc_type_at_fire", int'(evt_type), q.pop_front());
      exp_valid = 1'b0;
    end
    cyc();
    tick      = 1'b0;
    evt_ready = 1'b0;
    rand_in   = base_r;
    if (!exp_valid) begin
      q.push_back(type_tbl[int'(fire_r[2:0])]);
      exp_valid = 1'b1;
    end else if (exp_drop < 15) begin
      exp_drop++;
    end
    chk("fire_valid", int'(evt_valid), 1);
    chk("fire_type", int'(evt_type), q[0]);
    chk("fire_dropped", int'(evt_dropped), exp_drop);
    cyc();
  endtask

  // Consumer takes the pending event.
  task automatic accept_evt();
    tick      = 1'b0;
    evt_ready = 1'b1;
    chk("acc_valid", int'(evt_valid), 1);
    chk("acc_type", int'(evt_type), q.pop_front());
    exp_valid = 1'b0;
    cyc();
    evt_ready = 1'b0;
    chk("acc_cleared", int'(evt_valid), 0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; enable = 1'b0; evt_ready = 1'b0;
    exp_valid = 1'b0; exp_drop = 0;
    set_base(8'h05);
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_type", int'(evt_type), 0);
    chk("rst_dropped", int'(evt_dropped), 0);
    chk("rst_min_valid", int'(evt_valid1), 0);

    // 21-tick interval, SICK on the last tick.
    enable = 1'b1;
    cyc(); cyc();
    do_fire(8'h07, 1'b0);
    accept_evt();

    // Type table sweep over rand_in[2:0].
    for (int k = 0; k < 8; k++) begin
      do_fire({5'($urandom), 3'(k)}, 1'b0);
      accept_evt();
    end

    // Fire coinciding with acceptance of a pending event.
    do_fire(8'h01, 1'b0);
    do_fire(8'h06, 1'b1);
    accept_evt();

    // Disable with cnt=3 while an event is pending.
    do_fire(8'h0B, 1'b0);
    tick = 1'b1;
    for (int i = 0; i < load_len - 3; i++) cyc();
    tick = 1'b0;
    enable = 1'b0;
    cyc();
    tick = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    tick = 1'b0;
    chk("dis_valid", int'(evt_valid), 1);
    chk("dis_type", int'(evt_type), q[0]);
    chk("dis_dropped", int'(evt_dropped), exp_drop);
    set_base(8'h0A);
    enable = 1'b1;
    cyc(); cyc();
    accept_evt();
    do_fire(8'h05, 1'b0);
    accept_evt();

    // Seventeen fires with no consumer: drop count saturates.
    do_fire(8'h03, 1'b0);
    for (int i = 0; i < 16; i++) do_fire(8'($urandom), 1'b0);
    chk("sat_dropped", int'(evt_dropped), 15);
    chk("sat_type", int'(evt_type), 1);
    chk("sat_valid", int'(evt_valid), 1);
    accept_evt();

    // Reset mid-count with an event pending.
    do_fire(8'h07, 1'b0);
    tick = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    tick = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q.delete(); exp_valid = 1'b0; exp_drop = 0;
    chk("rst2_valid", int'(evt_valid), 0);
    chk("rst2_type", int'(evt_type), 0);
    chk("rst2_dropped", int'(evt_dropped), 0);
    chk("rst2_min_valid", int'(evt_valid1), 0);

    // MIN_INTERVAL=1 with zero masked byte fires on the first tick.
    rand_in = 8'h40;
    cyc(); cyc();
    chk("min_pre_valid", int'(evt_valid1), 0);
    tick = 1'b1;
    rand_in = 8'h04;
    cyc();
    tick = 1'b0;
    chk("min_fire_valid", int'(evt_valid1), 1);
    chk("min_fire_type", int'(evt_type1), 1);
    chk("min_fire_dropped", int'(evt_dropped1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
